// File: rtl/mmio_bridge_if.sv
// mmio_bridge_if: CPU-side valid/ready request and one-cycle response bus
interface mmio_bridge_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_acc;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        stall;
  modport slave (
    input  req_valid, req_we, req_acc, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_err, stall
  );
  modport master (
    output req_valid, req_we, req_acc, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err, stall
  );
endinterface

// File: rtl/mmio_bridge.sv
// mmio_bridge: sequences CPU MMIO accesses into fifo_if register cycles or the local IRQ registers
module mmio_bridge #(
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  mmio_bridge_if.slave bus,
  output logic        fifo_sel_o,
  output logic        fifo_rd_o,
  output logic        fifo_wr_o,
  output logic [1:0]  fifo_addr_o,
  output logic [7:0]  fifo_wdata_o,
  input  logic [7:0]  fifo_rdata_i,
  input  logic        fifo_in_irq_i,
  input  logic        fifo_out_irq_i,
  output logic        irq_o
);
  typedef enum logic [2:0] {IDLE, FWR, FRD, FCAP, RSP} state_t;
  state_t      state, state_nx;
  logic [31:0] off, local_rd, rsp_data_q;
  logic [1:0]  idx_q, irq_en_q;
  logic [7:0]  wdata_q;
  logic        err, accept, rsp_err_q, irq_q;
  logic        unused_wdata;
  assign unused_wdata = ^bus.req_wdata[31:8];
  assign off = bus.req_addr - MMIO_BASE;
  // out-of-window (wrapping subtraction covers addresses below the base), misaligned, bad size, reserved
  assign err = |off[31:5] | |off[1:0] | &bus.req_acc | &off[4:3];
  assign accept = (state == IDLE) & bus.req_valid & ~rst_i;
  assign local_rd = (err | bus.req_we | ~off[4]) ? 32'd0
                  : {30'd0, off[2] ? {fifo_out_irq_i, fifo_in_irq_i} : irq_en_q};
  assign bus.req_ready = accept;
  assign bus.rsp_valid = state == RSP;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err = rsp_err_q;
  assign bus.stall = bus.req_valid & ~bus.rsp_valid;
  assign fifo_wr_o = state == FWR;
  assign fifo_rd_o = state == FRD;
  assign fifo_sel_o = fifo_wr_o | fifo_rd_o;
  assign fifo_addr_o = fifo_sel_o ? idx_q : 2'd0;
  assign fifo_wdata_o = fifo_wr_o ? wdata_q : 8'd0;
  assign irq_o = irq_q;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (~accept ? IDLE : (err | off[4]) ? RSP : bus.req_we ? FWR : FRD)
             : state == FRD  ? FCAP
             : state == RSP  ? IDLE
             : RSP;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      idx_q      <= 2'd0;
      wdata_q    <= 8'd0;
      rsp_data_q <= 32'd0;
      rsp_err_q  <= 1'b0;
      irq_en_q   <= 2'd0;
      irq_q      <= 1'b0;
    end else begin
      state <= state_nx;
      irq_q <= |(irq_en_q & {fifo_out_irq_i, fifo_in_irq_i});
      if (accept) begin
        idx_q      <= off[3:2];
        wdata_q    <= bus.req_wdata[7:0];
        rsp_err_q  <= err;
        rsp_data_q <= local_rd;
        if (~err & (off[4:2] == 3'b100) & bus.req_we) irq_en_q <= bus.req_wdata[1:0];
      end
      if (state == FCAP) rsp_data_q <= {24'd0, fifo_rdata_i};
    end
  end
endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: randomized and directed accesses checked every cycle against a schedule-based model
module tb_mmio_bridge;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int K_W = 1, K_R = 2, K_CAP = 3, K_RSP = 4;
  typedef struct {
    int         kind;
    logic [1:0] a;
    logic [7:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_sel, fifo_rd, fifo_wr, irq;
  logic [1:0] fifo_addr;
  logic [7:0] fifo_wdata, fifo_rdata = 8'd0;
  logic       fin = 1'b0, fout = 1'b0;
  bit         rand_irq = 1'b0, force_rd = 1'b0;
  logic [7:0] force_val = 8'd0;
  int         checks = 0, failures = 0;

  mmio_bridge_if bus();

  mmio_bridge #(.MMIO_BASE(BASE)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .fifo_sel_o(fifo_sel), .fifo_rd_o(fifo_rd), .fifo_wr_o(fifo_wr),
    .fifo_addr_o(fifo_addr), .fifo_wdata_o(fifo_wdata), .fifo_rdata_i(fifo_rdata),
    .fifo_in_irq_i(fin), .fifo_out_irq_i(fout), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: each accepted request expands into a list of per-cycle events
  ev_t        sched[$];
  logic [1:0] irq_en_m = 2'd0;
  logic       irq_m = 1'b0, err_m = 1'b0, armed = 1'b0;
  logic [31:0] rd_m = 32'd0;

  always @(negedge clk) begin
    ev_t h;
    logic [31:0] off;
    logic e_sel, e_rsp;
    h = sched.size() != 0 ? sched[0] : '{0, 2'd0, 8'd0};
    e_sel = h.kind == K_W || h.kind == K_R;
    e_rsp = h.kind == K_RSP;
    if (armed) begin
      chk("m_ready", bus.req_ready, !rst && sched.size() == 0 && bus.req_valid);
      chk("m_rsp_valid", bus.rsp_valid, e_rsp);
      chk("m_rsp_err", bus.rsp_err, err_m);
      chk("m_rsp_data", bus.rsp_data, rd_m);
      chk("m_stall", bus.stall, bus.req_valid && !e_rsp);
      chk("m_sel", fifo_sel, e_sel);
      chk("m_rd", fifo_rd, h.kind == K_R);
      chk("m_wr", fifo_wr, h.kind == K_W);
      chk("m_addr", fifo_addr, e_sel ? h.a : 2'd0);
      chk("m_wdata", fifo_wdata, h.kind == K_W ? h.d : 8'd0);
      chk("m_irq", irq, irq_m);
    end
    if (rst) begin
      sched.delete();
      irq_en_m = 2'd0; irq_m = 1'b0; rd_m = 32'd0; err_m = 1'b0; armed = 1'b1;
    end else begin
      irq_m = |(irq_en_m & {fout, fin});
      if (sched.size() != 0) begin
        if (sched[0].kind == K_CAP) rd_m = {24'd0, fifo_rdata};
        void'(sched.pop_front());
      end else if (bus.req_valid) begin
        off = bus.req_addr - BASE;
        rd_m = 32'd0;
        err_m = off >= 32 || off % 4 != 0 || bus.req_acc == 2'd3 || off >= 24;
        if (err_m) sched.push_back('{K_RSP, 2'd0, 8'd0});
        else if (off < 16) begin
          if (bus.req_we) sched.push_back('{K_W, off[3:2], bus.req_wdata[7:0]});
          else begin
            sched.push_back('{K_R, off[3:2], 8'd0});
            sched.push_back('{K_CAP, 2'd0, 8'd0});
          end
          sched.push_back('{K_RSP, 2'd0, 8'd0});
        end else begin
          if (!bus.req_we) rd_m = off == 16 ? {30'd0, irq_en_m} : {30'd0, fout, fin};
          else if (off == 16) irq_en_m = bus.req_wdata[1:0];
          sched.push_back('{K_RSP, 2'd0, 8'd0});
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_irq) begin fin = 1'($urandom); fout = 1'($urandom); end
    fifo_rdata = force_rd ? force_val : 8'($urandom);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic access(input logic we, input logic [1:0] acc, input logic [31:0] addr,
                        input logic [31:0] wd, input bit hold,
                        output logic [31:0] rd, output logic err, output int lat);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_acc = acc;
    bus.req_addr = addr; bus.req_wdata = wd;
    lat = 0;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid) break;
      lat++;
      if (lat > 20) begin
        chk("rsp_timeout", 32'(lat), 32'd0);
        break;
      end
    end
    rd = bus.rsp_data; err = bus.rsp_err;
    step();
    if (!hold) bus.req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, addr;
    logic err;
    int l1, l2, l3;
    logic [31:0] bad [3];
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_acc = 2'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_irq", irq, 1'b0);
    chk("reset_sel", fifo_sel, 1'b0);
    chk("reset_rsp_data", bus.rsp_data, 32'd0);
    step();

    // FIFO word store, strobes checked cycle by cycle
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_acc = 2'b10;
    bus.req_addr = BASE + 32'h8; bus.req_wdata = 32'h0000_00A5;
    @(negedge clk);
    chk("wr_T_stall", bus.stall, 1'b1);
    @(negedge clk);
    chk("wr_T1_sel", fifo_sel, 1'b1);
    chk("wr_T1_wr", fifo_wr, 1'b1);
    chk("wr_T1_addr", fifo_addr, 2'd2);
    chk("wr_T1_wdata", fifo_wdata, 8'hA5);
    chk("wr_T1_stall", bus.stall, 1'b1);
    @(negedge clk);
    chk("wr_T2_rsp", bus.rsp_valid, 1'b1);
    chk("wr_T2_err", bus.rsp_err, 1'b0);
    step();
    bus.req_valid = 1'b0;
    step();

    force_val = 8'h9C; force_rd = 1'b1;
    access(1'b0, 2'b00, BASE + 32'h4, 32'd0, 1'b0, rd, err, l1);
    chk("rd_latency", 32'(l1), 32'd3);
    chk("rd_data", rd, 32'h0000_009C);
    force_rd = 1'b0;

    bad[0] = BASE + 32'h2; bad[1] = BASE + 32'h18; bad[2] = BASE + 32'h40;
    foreach (bad[i]) begin
      access(1'b0, 2'b10, bad[i], 32'd0, 1'b0, rd, err, l1);
      chk("err_latency", 32'(l1), 32'd1);
      chk("err_flag", err, 1'b1);
      chk("err_data", rd, 32'd0);
    end

    fin = 1'b1; fout = 1'b1;
    step();
    access(1'b1, 2'b10, BASE + 32'h10, 32'd2, 1'b0, rd, err, l1);
    @(negedge clk);
    chk("irq_rise", irq, 1'b1);
    step();
    access(1'b0, 2'b10, BASE + 32'h14, 32'd0, 1'b0, rd, err, l1);
    chk("irq_stat", rd, 32'd3);
    access(1'b0, 2'b10, BASE + 32'h10, 32'd0, 1'b0, rd, err, l1);
    chk("irq_en_read", rd, 32'd2);
    access(1'b1, 2'b10, BASE + 32'h10, 32'd0, 1'b0, rd, err, l1);
    @(negedge clk);
    chk("irq_fall", irq, 1'b0);
    step();

    access(1'b0, 2'b10, BASE + 32'hC, 32'd0, 1'b1, rd, err, l1);
    access(1'b1, 2'b01, BASE + 32'h0, 32'h1234_5655, 1'b1, rd, err, l2);
    access(1'b0, 2'b10, BASE + 32'h14, 32'd0, 1'b0, rd, err, l3);
    chk("b2b_space1", 32'(l1 + 1), 32'd4);
    chk("b2b_space2", 32'(l2 + 1), 32'd3);
    chk("b2b_local", 32'(l3), 32'd1);

    // reset asserted while the FIFO read strobe is out
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_acc = 2'b10; bus.req_addr = BASE;
    step();
    chk("rst_mid_frd", fifo_rd, 1'b1);
    rst = 1'b1; bus.req_valid = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sel", fifo_sel, 1'b0);
    chk("rst_rd", fifo_rd, 1'b0);
    chk("rst_rsp", bus.rsp_valid, 1'b0);
    chk("rst_irq", irq, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_rsp", bus.rsp_valid, 1'b0);
    end
    step();

    rand_irq = 1'b1;
    for (int n = 0; n < 250; n++) begin
      int r;
      bit hold;
      r = $urandom_range(0, 9);
      if (r == 0) addr = $urandom;
      else if (r == 1) addr = BASE - 32'(4 * $urandom_range(1, 4));
      else begin
        addr = BASE + 32'(4 * $urandom_range(0, 9));
        if ($urandom_range(0, 4) == 0) addr = addr + 32'($urandom_range(1, 3));
      end
      hold = 1'($urandom);
      access(1'($urandom), 2'($urandom), addr, $urandom, hold, rd, err, l1);
      if (!hold) repeat ($urandom_range(0, 2)) step();
    end
    bus.req_valid = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
